// File: rtl/instr_loader.sv
// Byte-stream program loader feeding the fetch stage's instruction-memory write port.
// Optional trailing XOR checksum byte after the HALT word when LOADER_CHECKSUM_EN is defined.
module instr_loader #(
  parameter int unsigned           INSTMEM_SIZE = 8,
  parameter int unsigned           MEM_SIZE     = 8,
  parameter int unsigned           INST_SIZE    = 32,
  parameter logic [INST_SIZE-1:0]  HALT_INSTR   = 32'hFFFFFFFF
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_rx_valid,
  output logic                    o_write_en,
  output logic [MEM_SIZE-1:0]     o_write_data,
  output logic [INSTMEM_SIZE-1:0] o_write_addr,
  output logic                    o_instrmem_en,
  output logic                    o_pc_reset,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error,
  output logic [INSTMEM_SIZE-3:0] o_word_count
);

  localparam int unsigned WcW = INSTMEM_SIZE - 2;
  localparam logic [INSTMEM_SIZE-1:0] PtrOne = INSTMEM_SIZE'(1);
  localparam logic [WcW-1:0]          WcOne  = WcW'(1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StCheck = 3'd2,
    StDone  = 3'd3,
    StError = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StDone  = 3'd3,
    StError = 3'd4
  } state_e;
`endif

  state_e                  state_q, state_d;
  logic [INSTMEM_SIZE-1:0] ptr_q, ptr_d;
  // Only the three most recent bytes are kept; the full word is {word_q, incoming byte}.
  logic [INST_SIZE-9:0]    word_q, word_d;
  logic [INST_SIZE-1:0]    word_next;
  logic [WcW-1:0]          wcnt_q, wcnt_d;
  logic                    write_en_q, write_en_d;
  logic [MEM_SIZE-1:0]     write_data_q, write_data_d;
  logic [INSTMEM_SIZE-1:0] write_addr_q, write_addr_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]              csum_q, csum_d;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    word_d       = word_q;
    wcnt_d       = wcnt_q;
    write_en_d   = 1'b0;
    write_data_d = write_data_q;
    write_addr_d = write_addr_q;
    word_next    = {word_q, i_rx_data};
`ifdef LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (i_start) begin
          state_d = StLoad;
          ptr_d   = '0;
          word_d  = '0;
          wcnt_d  = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      StLoad: begin
        if (i_rx_valid) begin
          write_en_d   = 1'b1;
          write_data_d = MEM_SIZE'(i_rx_data);
          write_addr_d = ptr_q;
          word_d       = word_next[INST_SIZE-9:0];
`ifdef LOADER_CHECKSUM_EN
          csum_d       = csum_q ^ i_rx_data;
`endif
          // Saturate rather than wrap; the last address always ends the load anyway.
          if (ptr_q != '1) begin
            ptr_d = ptr_q + PtrOne;
          end
          if (ptr_q[1:0] == 2'b11) begin
            wcnt_d = wcnt_q + WcOne;
            if (word_next == HALT_INSTR) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = StCheck;
`else
              state_d = StDone;
`endif
            end else if (ptr_q == '1) begin
              state_d = StError;
            end
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        if (i_rx_valid) begin
          state_d = (i_rx_data == csum_q) ? StDone : StError;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      word_q       <= '0;
      wcnt_q       <= '0;
      write_en_q   <= 1'b0;
      write_data_q <= '0;
      write_addr_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      word_q       <= word_d;
      wcnt_q       <= wcnt_d;
      write_en_q   <= write_en_d;
      write_data_q <= write_data_d;
      write_addr_q <= write_addr_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  logic busy;
`ifdef LOADER_CHECKSUM_EN
  assign busy = (state_q == StLoad) || (state_q == StCheck);
`else
  assign busy = (state_q == StLoad);
`endif

  assign o_write_en    = write_en_q;
  assign o_write_data  = write_data_q;
  assign o_write_addr  = write_addr_q;
  assign o_instrmem_en = busy;
  assign o_pc_reset    = busy;
  assign o_busy        = busy;
  assign o_done        = (state_q == StDone);
  assign o_error       = (state_q == StError);
  assign o_word_count  = wcnt_q;

endmodule
